// File: rtl/gf_matvec_serial_if.sv
// Handshake and operand/result bus for gf_matvec_serial.
// The master drives operands and out_ready; the slave (engine) drives status and result.
interface gf_matvec_serial_if #(
  parameter int unsigned N    = 8,
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [ROWS*COLS*N-1:0]   mat;
  logic [COLS*N-1:0]        vec;
  logic [N:0]               poly;
  logic                     out_valid;
  logic                     out_ready;
  logic [ROWS*N-1:0]        result;
  logic                     busy;

  modport master (
    output in_valid, mat, vec, poly, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, mat, vec, poly, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/gf_matvec_serial.sv
// GF(2^N) matrix-vector engine s = A*v using one time-shared MSB-first bit-serial
// multiplier; ROWS*COLS*N cycles per operation, run-time reduction polynomial.
module gf_matvec_serial #(
  parameter int unsigned N    = 8,
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 4
) (
  input logic              clk,
  input logic              rst_n,
  gf_matvec_serial_if.slave bus
);

  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned BW = $clog2(N);

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e                 state_q, state_d;
  logic [ROWS*COLS*N-1:0] mat_q, mat_d;
  logic [COLS*N-1:0]      vec_q, vec_d;
  logic [N-1:0]           poly_q, poly_d;
  logic [RW-1:0]          r_q, r_d;
  logic [CW-1:0]          c_q, c_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [N-1:0]           prod_q, prod_d;
  logic [N-1:0]           sum_q, sum_d;
  logic [ROWS*N-1:0]      result_q, result_d;

  logic [N-1:0]           mat_el, xt, prod_next, sum_next;
  logic                   vec_bit;
  int unsigned            mat_base, vec_base;

  // poly[N] is implied to be 1 and never consulted.
  logic unused_poly_msb;
  assign unused_poly_msb = bus.poly[N];

  always_comb begin
    mat_base  = (32'(r_q) * COLS + 32'(c_q)) * N;
    vec_base  = 32'(c_q) * N;
    mat_el    = mat_q[mat_base +: N];
    vec_bit   = vec_q[vec_base + 32'(bit_q)];
    xt        = {prod_q[N-2:0], 1'b0} ^ (prod_q[N-1] ? poly_q : '0);
    prod_next = xt ^ (vec_bit ? mat_el : '0);
    sum_next  = sum_q ^ prod_next;
  end

  always_comb begin
    state_d  = state_q;
    mat_d    = mat_q;
    vec_d    = vec_q;
    poly_d   = poly_q;
    r_d      = r_q;
    c_d      = c_q;
    bit_d    = bit_q;
    prod_d   = prod_q;
    sum_d    = sum_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          mat_d   = bus.mat;
          vec_d   = bus.vec;
          poly_d  = bus.poly[N-1:0];
          r_d     = '0;
          c_d     = '0;
          bit_d   = BW'(N - 1);
          prod_d  = '0;
          sum_d   = '0;
          state_d = StMul;
        end
      end
      StMul: begin
        if (bit_q != '0) begin
          prod_d = prod_next;
          bit_d  = bit_q - 1'b1;
        end else begin
          prod_d = '0;
          bit_d  = BW'(N - 1);
          if (c_q != CW'(COLS - 1)) begin
            sum_d = sum_next;
            c_d   = c_q + 1'b1;
          end else begin
            result_d[32'(r_q)*N +: N] = sum_next;
            sum_d = '0;
            c_d   = '0;
            if (r_q != RW'(ROWS - 1)) r_d = r_q + 1'b1;
            else                      state_d = StDone;
          end
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      mat_q    <= '0;
      vec_q    <= '0;
      poly_q   <= '0;
      r_q      <= '0;
      c_q      <= '0;
      bit_q    <= '0;
      prod_q   <= '0;
      sum_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mat_q    <= mat_d;
      vec_q    <= vec_d;
      poly_q   <= poly_d;
      r_q      <= r_d;
      c_q      <= c_d;
      bit_q    <= bit_d;
      prod_q   <= prod_d;
      sum_q    <= sum_d;
      result_q <= result_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q != StIdle);
  assign bus.result    = result_q;

endmodule

// File: tb/tb_gf_matvec_serial.sv
// Bench for gf_matvec_serial: fixed AES linear-layer vectors, random operands against
// a polynomial-arithmetic model, backpressure, busy-time input, and mid-run reset.
module tb_gf_matvec_serial;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gf_matvec_serial_if #(.N(8), .ROWS(4), .COLS(4)) mif ();
  gf_matvec_serial_if #(.N(8), .ROWS(1), .COLS(1)) s8if ();
  gf_matvec_serial_if #(.N(4), .ROWS(1), .COLS(1)) s4if ();

  gf_matvec_serial #(.N(8), .ROWS(4), .COLS(4)) u_main (.clk(clk), .rst_n(rst_n), .bus(mif));
  gf_matvec_serial #(.N(8), .ROWS(1), .COLS(1)) u_s8   (.clk(clk), .rst_n(rst_n), .bus(s8if));
  gf_matvec_serial #(.N(4), .ROWS(1), .COLS(1)) u_s4   (.clk(clk), .rst_n(rst_n), .bus(s4if));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Carry-less product followed by long division by poly (poly includes bit n).
  function automatic int unsigned gmul(int unsigned a, int unsigned b, int unsigned p, int n);
    int unsigned acc = 0;
    for (int i = 0; i < n; i++) if (b[i]) acc ^= a << i;
    for (int i = 2 * n - 2; i >= n; i--) if (acc[i]) acc ^= p << (i - n);
    return acc & ((32'd1 << n) - 1);
  endfunction

  function automatic logic [31:0] matvec(input logic [127:0] m, input logic [31:0] v,
                                         input logic [8:0] p);
    logic [31:0] res;
    for (int r = 0; r < 4; r++) begin
      int unsigned acc = 0;
      for (int c = 0; c < 4; c++)
        acc ^= gmul(32'(m[(r*4+c)*8 +: 8]), 32'(v[c*8 +: 8]), 32'(p), 8);
      res[r*8 +: 8] = acc[7:0];
    end
    return res;
  endfunction

  // Byte reversal so constants can be written in reading order (element 0 first).
  function automatic logic [127:0] rb128(input logic [127:0] x);
    for (int i = 0; i < 16; i++) rb128[i*8 +: 8] = x[(15-i)*8 +: 8];
  endfunction
  function automatic logic [31:0] rb32(input logic [31:0] x);
    for (int i = 0; i < 4; i++) rb32[i*8 +: 8] = x[(3-i)*8 +: 8];
  endfunction

  typedef struct {
    logic [127:0] mat;
    logic [31:0]  vec;
    logic [31:0]  exp;
  } vec_t;
  vec_t tab [3];

  // Issue one operation on the 4x4 engine; returns result and the cycle out_valid rose.
  task automatic go_main(input logic [127:0] m, input logic [31:0] v, input logic [8:0] p,
                         output logic [31:0] res, output int lat);
    int k = 0;
    mif.mat = m; mif.vec = v; mif.poly = p; mif.in_valid = 1'b1;
    while (!mif.in_ready && k < 300) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    mif.in_valid = 1'b0;
    lat = 1;
    while (!mif.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    if (!mif.out_valid) lat = -1;
    res = mif.result;
  endtask

  task automatic release_main();
    mif.out_ready = 1'b1;
    @(posedge clk); #1;
    mif.out_ready = 1'b0;
  endtask

  logic [31:0]  res, exp;
  logic [127:0] m;
  logic [31:0]  v;
  logic [8:0]   p;
  int           lat, bad_rdy, bad_busy, bad_hold;

  initial begin
    tab[0] = '{rb128(128'h02030101_01020301_01010203_03010102), rb32(32'hDB135345),
               rb32(32'h8E4DA1BC)};
    tab[1] = '{rb128(128'h0E0B0D09_090E0B0D_0D090E0B_0B0D090E), rb32(32'h8E4DA1BC),
               rb32(32'hDB135345)};
    tab[2] = '{rb128(128'h01000000_00010000_00000100_00000001), rb32(32'h01FF8000),
               rb32(32'h01FF8000)};

    rst_n = 1'b0;
    mif.in_valid = 0; mif.mat = '0; mif.vec = '0; mif.poly = '0; mif.out_ready = 0;
    s8if.in_valid = 0; s8if.mat = '0; s8if.vec = '0; s8if.poly = '0; s8if.out_ready = 0;
    s4if.in_valid = 0; s4if.mat = '0; s4if.vec = '0; s4if.poly = '0; s4if.out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(mif.in_ready), 64'd1);
    check("rst_out_valid", 64'(mif.out_valid), 64'd0);
    check("rst_busy", 64'(mif.busy), 64'd0);
    check("rst_result", 64'(mif.result), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) begin
      go_main(tab[i].mat, tab[i].vec, 9'h11B, res, lat);
      check($sformatf("tab%0d_result", i), 64'(res), 64'(tab[i].exp));
      check($sformatf("tab%0d_latency", i), 64'(lat), 64'd129);
      release_main();
    end

    for (int i = 0; i < 4; i++) begin
      m = {$urandom, $urandom, $urandom, $urandom};
      v = $urandom;
      p = {1'b1, 8'($urandom)};
      go_main(m, v, p, res, lat);
      check($sformatf("rand%0d_result", i), 64'(res), 64'(matvec(m, v, p)));
      release_main();
    end

    // Busy-time input: new operands offered throughout MUL and DONE must be ignored.
    bad_rdy = 0; bad_busy = 0; bad_hold = 0;
    mif.mat = tab[0].mat; mif.vec = tab[0].vec; mif.poly = 9'h11B; mif.in_valid = 1'b1;
    @(posedge clk); #1;
    mif.mat = tab[2].mat; mif.vec = 32'hFFFF_FFFF;
    lat = 1;
    while (!mif.out_valid && lat < 200) begin
      if (mif.in_ready) bad_rdy++;
      if (!mif.busy) bad_busy++;
      @(posedge clk); #1; lat++;
    end
    check("busy_latency", 64'(lat), 64'd129);
    exp = tab[0].exp;
    for (int i = 0; i < 10; i++) begin
      if (mif.in_ready || !mif.busy) bad_rdy++;
      if (!mif.out_valid || mif.result !== exp) bad_hold++;
      @(posedge clk); #1;
    end
    check("busy_in_ready_low", 64'(bad_rdy), 64'd0);
    check("busy_flag_high", 64'(bad_busy), 64'd0);
    check("backpressure_hold", 64'(bad_hold), 64'd0);
    check("busy_result", 64'(mif.result), 64'(exp));
    mif.in_valid = 1'b0;
    release_main();
    check("in_ready_after_out", 64'(mif.in_ready), 64'd1);
    go_main(tab[1].mat, tab[1].vec, 9'h11B, res, lat);
    check("second_op_result", 64'(res), 64'(tab[1].exp));
    release_main();

    // Reset in cycle 50 of a MixColumns run.
    mif.mat = tab[0].mat; mif.vec = tab[0].vec; mif.poly = 9'h11B; mif.in_valid = 1'b1;
    @(posedge clk); #1;
    mif.in_valid = 1'b0;
    for (int k = 1; k < 50; k++) begin @(posedge clk); #1; end
    check("pre_rst_busy", 64'(mif.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 64'(mif.in_ready), 64'd1);
    check("midrst_busy", 64'(mif.busy), 64'd0);
    check("midrst_result", 64'(mif.result), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    go_main(tab[0].mat, tab[0].vec, 9'h11B, res, lat);
    check("post_rst_result", 64'(res), 64'(tab[0].exp));
    check("post_rst_latency", 64'(lat), 64'd129);
    release_main();

    // Single multiply, N=8: latency N, out_valid in cycle 9.
    s8if.mat = 8'h57; s8if.vec = 8'h83; s8if.poly = 9'h11B; s8if.in_valid = 1'b1;
    @(posedge clk); #1;
    s8if.in_valid = 1'b0;
    lat = 1;
    while (!s8if.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    check("s8_result", 64'(s8if.result), 64'h C1);
    check("s8_latency", 64'(lat), 64'd9);
    s8if.out_ready = 1'b1;
    @(posedge clk); #1;
    s8if.out_ready = 1'b0;

    for (int i = 0; i < 6; i++) begin
      m = 128'($urandom_range(255)); v = 32'($urandom_range(255));
      p = {1'b1, 8'($urandom)};
      s8if.mat = m[7:0]; s8if.vec = v[7:0]; s8if.poly = p; s8if.in_valid = 1'b1;
      @(posedge clk); #1;
      s8if.in_valid = 1'b0;
      lat = 1;
      while (!s8if.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
      check($sformatf("s8_rand%0d", i), 64'(s8if.result),
            64'(gmul(32'(m[7:0]), 32'(v[7:0]), 32'(p), 8)));
      s8if.out_ready = 1'b1;
      @(posedge clk); #1;
      s8if.out_ready = 1'b0;
    end

    // Single multiply, N=4, out_ready already high: one-cycle out_valid.
    s4if.out_ready = 1'b1;
    s4if.mat = 4'h7; s4if.vec = 4'h9; s4if.poly = 5'h13; s4if.in_valid = 1'b1;
    @(posedge clk); #1;
    s4if.in_valid = 1'b0;
    lat = 1;
    while (!s4if.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    check("s4_result", 64'(s4if.result), 64'hA);
    check("s4_latency", 64'(lat), 64'd5);
    @(posedge clk); #1;
    check("s4_valid_one_cycle", 64'(s4if.out_valid), 64'd0);
    check("s4_in_ready_back", 64'(s4if.in_ready), 64'd1);
    s4if.out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
